// File: rtl/press_classifier_if.sv
// press_classifier_if: button, counter handshake and press-event signals of press_classifier
interface press_classifier_if;
  logic button_n;
  logic long_done;
  logic long_enable;
  logic long_clear;
  logic held;
  logic long_held;
  logic short_press;
  logic long_press;
  modport slave (
    input  button_n, long_done,
    output long_enable, long_clear, held, long_held, short_press, long_press
  );
  modport master (
    output button_n, long_done,
    input  long_enable, long_clear, held, long_held, short_press, long_press
  );
endinterface

// File: rtl/press_classifier.sv
// press_classifier: sync+debounce button_n, drive counter (long_enable/long_clear, long_done in), emit held/long_held levels and short_press/long_press pulses
module press_classifier #(
  parameter int DEBOUNCE_PERIOD_ns = 100,
  parameter int CLK_PERIOD_ns      = 20
) (
  input logic clk,
  input logic reset,
  press_classifier_if.slave bus
);
  localparam int DEB_CYCLES = DEBOUNCE_PERIOD_ns / CLK_PERIOD_ns;
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [1:0] IDLE = 2'd0, TIMING = 2'd1, LONG = 2'd2;
  logic sync1, sync2, deb_pressed;
  logic [CW-1:0] deb_cnt;
  logic [1:0] state, nxt;
  logic long_enable_r, long_clear_r, held_r, long_held_r, short_r, long_r;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.button_n;
      sync2 <= sync1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      deb_pressed <= 1'b0;
      deb_cnt     <= '0;
    end else if ((!sync2) == deb_pressed) deb_cnt <= '0;
    else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
      deb_pressed <= !sync2;
      deb_cnt     <= '0;
    end else deb_cnt <= deb_cnt + 1'b1;
  // long_done wins over a simultaneous release in TIMING
  always_comb
    nxt = state == IDLE   ? (deb_pressed ? TIMING : IDLE) :
          state == TIMING ? (bus.long_done ? LONG : deb_pressed ? TIMING : IDLE) :
                            (deb_pressed ? LONG : IDLE);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      long_clear_r  <= 1'b0;
      long_enable_r <= 1'b0;
      held_r        <= 1'b0;
      long_held_r   <= 1'b0;
      short_r       <= 1'b0;
      long_r        <= 1'b0;
    end else begin
      state         <= nxt;
      long_clear_r  <= state == IDLE && nxt == TIMING;
      long_enable_r <= nxt == TIMING;
      held_r        <= nxt != IDLE;
      long_held_r   <= nxt == LONG;
      short_r       <= state == TIMING && nxt == IDLE;
      long_r        <= state == TIMING && nxt == LONG;
    end
  assign bus.long_clear  = long_clear_r;
  assign bus.long_enable = long_enable_r;
  assign bus.held        = held_r;
  assign bus.long_held   = long_held_r;
  assign bus.short_press = short_r;
  assign bus.long_press  = long_r;
endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed and random stimulus checked against a behavioural press model
module tb_press_classifier;
  localparam int D = 100 / 20;
  localparam int LONG_CYCLES = 9;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic force_done = 1'b0;
  int cnt = 0;
  int vectors = 0, miscompares = 0;
  int n_short = 0, n_long = 0, n_clear = 0, n_held = 0;
  press_classifier_if bus ();
  press_classifier dut (.clk(clk), .reset(reset), .bus(bus));
  always #10 clk = ~clk;
  // counter stand-in: reloads on long_clear, done after LONG_CYCLES enabled cycles
  assign bus.long_done = force_done | (cnt >= LONG_CYCLES);
  logic raw1, raw2, m_deb, m_press, m_long;
  logic [D-1:0] win;
  logic m_clear, m_enable, m_held, m_lheld, m_short, m_lp;
  always @(posedge clk or posedge reset) begin : model
    logic p, l, c, s, lp;
    logic [D-1:0] w;
    if (reset) begin
      raw1 <= 1'b1; raw2 <= 1'b1; win <= '1; m_deb <= 1'b0;
      m_press <= 1'b0; m_long <= 1'b0;
      {m_clear, m_enable, m_held, m_lheld, m_short, m_lp} <= '0;
    end else begin
      p = m_press; l = m_long; c = 1'b0; s = 1'b0; lp = 1'b0;
      if (!m_press && m_deb) begin p = 1'b1; c = 1'b1; end
      else if (m_press && !m_long) begin
        if (bus.long_done) begin l = 1'b1; lp = 1'b1; end
        else if (!m_deb) begin p = 1'b0; s = 1'b1; end
      end else if (m_long && !m_deb) begin p = 1'b0; l = 1'b0; end
      // debounced level flips once the last D synchronised samples all disagree with it
      w = {win[D-2:0], raw2};
      win <= w;
      if (w == {D{m_deb}}) m_deb <= !m_deb;
      raw1 <= bus.button_n; raw2 <= raw1;
      m_press <= p; m_long <= l;
      m_clear <= c; m_enable <= p && !l; m_held <= p; m_lheld <= l; m_short <= s; m_lp <= lp;
    end
  end
  always @(negedge clk or posedge reset)
    if (reset) cnt <= 0;
    else if (m_clear) cnt <= 0;
    else if (m_enable && cnt < 15) cnt <= cnt + 1;
  wire [5:0] dut_v = {bus.long_clear, bus.long_enable, bus.held, bus.long_held, bus.short_press, bus.long_press};
  wire [5:0] mod_v = {m_clear, m_enable, m_held, m_lheld, m_short, m_lp};
  always @(negedge clk) begin
    vectors++;
    if (dut_v !== mod_v) begin
      miscompares++;
      $display("FAIL outputs t=%0t got clr/en/held/lheld/short/long=%b expected %b", $time, dut_v, mod_v);
    end
    if (bus.short_press) n_short++;
    if (bus.long_press) n_long++;
    if (bus.long_clear) n_clear++;
    if (bus.held) n_held++;
  end
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic sig(input int sel);
    case (sel)
      0: return bus.held;
      1: return bus.long_clear;
      2: return bus.long_press;
      3: return bus.long_held;
      default: return bus.short_press;
    endcase
  endfunction
  task automatic edges_until(input int sel, input logic val, output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sig(sel) === val) begin n = i; return; end
    end
  endtask
  int n, s0, l0, c0, h0, run;
  initial begin
    bus.button_n = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", int'(dut_v), 0);
    reset = 1'b0;
    edges_until(0, 1'b1, n);
    chk("held_latency", n, 7);
    chk("clear_with_held", int'(bus.long_clear), 1);
    chk("enable_with_held", int'(bus.long_enable), 1);
    edges_until(2, 1'b1, n);
    chk("long_press_after_held", n, 9);
    chk("enable_drop_on_long", int'(bus.long_enable), 0);
    chk("long_held_on_long", int'(bus.long_held), 1);
    @(negedge clk) bus.button_n = 1'b1;
    edges_until(3, 1'b0, n);
    chk("long_held_release_latency", n, 7);
    repeat (5) @(negedge clk);
    s0 = n_short; l0 = n_long; c0 = n_clear; h0 = n_held;
    bus.button_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.button_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("glitch_held", n_held - h0, 0);
    chk("glitch_clear", n_clear - c0, 0);
    chk("glitch_events", n_short + n_long - s0 - l0, 0);
    s0 = n_short; l0 = n_long; c0 = n_clear;
    bus.button_n = 1'b0;
    repeat (8) @(negedge clk);
    bus.button_n = 1'b1;
    edges_until(4, 1'b1, n);
    chk("short_press_latency", n, 7);
    repeat (10) @(negedge clk);
    chk("short_clear_count", n_clear - c0, 1);
    chk("short_count", n_short - s0, 1);
    chk("short_no_long", n_long - l0, 0);
    s0 = n_short; l0 = n_long;
    bus.button_n = 1'b0;
    edges_until(0, 1'b1, n);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 chk("async_reset_zero", int'(dut_v), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    edges_until(1, 1'b1, n);
    chk("clear_after_reset", n, 7);
    edges_until(2, 1'b1, n);
    chk("long_after_reset", n, 9);
    @(negedge clk) bus.button_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("reset_press_long_count", n_long - l0, 1);
    chk("reset_press_short_count", n_short - s0, 0);
    s0 = n_short; l0 = n_long;
    bus.button_n = 1'b0;
    edges_until(0, 1'b1, n);
    repeat (2) @(negedge clk);
    bus.button_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!m_deb) begin n = 1; break; end
    end
    chk("release_seen", n, 1);
    force_done = 1'b1;
    @(posedge clk); #1;
    chk("tie_long_press", int'(bus.long_press), 1);
    chk("tie_no_short", int'(bus.short_press), 0);
    @(negedge clk) force_done = 1'b0;
    @(posedge clk); #1;
    chk("tie_back_idle", int'(bus.held), 0);
    repeat (5) @(negedge clk);
    chk("tie_event_count", (n_long - l0) * 10 + (n_short - s0), 10);
    run = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (run == 0) begin
        bus.button_n = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 30);
      end
      run--;
      force_done = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
    end
    force_done = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/press_classifier.md
# press_classifier

Front-end stage for the long-press counter (`counter`). It synchronises and debounces the raw active-low pushbutton, drives the counter's `enable` and `reset_sync` inputs, and consumes its `done` output. It emits one-cycle `short_press` / `long_press` events and held levels to the control logic downstream.

## Interface
- `DEBOUNCE_PERIOD_ns`, default 100: time the synchronised input must differ from the debounced level before the debounced level changes.
- `CLK_PERIOD_ns`, default 20: clock period. `DEB_CYCLES = DEBOUNCE_PERIOD_ns/CLK_PERIOD_ns`, so the default is 5. `DEB_CYCLES` ≥ 2 is required.
- `clk`  in  1  single system clock, all flops on rising edge.
- `reset`  in  1  asynchronous, active-high reset for every flop in the block.
- `button_n`  in  1  raw pushbutton, active-low, asynchronous to `clk`.
- `long_done`  in  1  from counter `done`; high once the long-press duration has elapsed.
- `long_enable`  out  1  to counter `enable`; high only in state TIMING.
- `long_clear`  out  1  to counter `reset_sync`; one-cycle pulse on entry to TIMING.
- `held`  out  1  high while a debounced press is in progress (TIMING or LONG).
- `long_held`  out  1  high in state LONG.
- `short_press`  out  1  one-cycle pulse: the button was released before `long_done`.
- `long_press`  out  1  one-cycle pulse: `long_done` was seen while pressed.

## Operation
**Synchroniser**
- Two flops, `sync1 <= button_n`, then `sync2 <= sync1`.
- Both reset to 1 (released).

**Debouncer**
- `deb_pressed` resets to 0. `deb_cnt` has width `$clog2(DEB_CYCLES)+1` and resets to 0.
- If `(!sync2) == deb_pressed`: `deb_cnt <= 0`.
- Else, if `deb_cnt == DEB_CYCLES-1`: `deb_pressed <= !sync2` and `deb_cnt <= 0`.
- Else: `deb_cnt <= deb_cnt + 1`.
- Any bounce back to the current debounced level restarts the count. No wrap is possible.

**FSM** (states IDLE, TIMING, LONG; resets to IDLE)
- IDLE: if `deb_pressed`, go to TIMING.
- TIMING: `long_done` takes priority. If `long_done`, go to LONG. Else if `!deb_pressed`, go to IDLE.
- LONG: if `!deb_pressed`, go to IDLE. Otherwise stay; no further events.

**Registered outputs** (all set on the edge that makes the transition)
- `long_clear` = 1 for exactly one cycle on IDLE→TIMING.
- `long_enable` = (next state == TIMING).
- `held` = (next state != IDLE).
- `long_held` = (next state == LONG).
- `short_press` = 1 for one cycle on TIMING→IDLE.
- `long_press` = 1 for one cycle on TIMING→LONG.
- Every output resets to 0.

**Boundary rules**
- `short_press` and `long_press` are never high together. At most one event is produced per debounced press.
- If the release and `long_done` arrive in the same cycle in TIMING, only `long_press` is produced. The FSM passes through LONG and returns to IDLE one cycle later.
- `long_done` is ignored in IDLE and LONG.
- Reset mid-press:
  - All outputs drop to 0 asynchronously.
  - After reset deasserts with the button still low, the press is re-debounced and timed from scratch as a new press.
  - No event is generated for the interrupted press.

## Timing
- Raw edge captured by `sync1` at edge E0. `sync2` updates at E1. `deb_pressed` changes at E(DEB_CYCLES+1).
- FSM state and outputs change at E(DEB_CYCLES+2). Raw-to-`held` latency is 7 edges at default parameters.
- `long_enable` rises in the same cycle as the `long_clear` pulse, so the counter reloads and then counts from its full value.
- `long_press` asserts on the edge after the first cycle in which `long_done`=1 is sampled.
- `short_press` asserts DEB_CYCLES+2 edges after the raw release is captured.
- Glitches shorter than DEB_CYCLES consecutive `sync2` cycles never reach the FSM.

## Test plan
Bench: default parameters, with `counter` instantiated at TIMER_PERIOD_ns=200 and CLK_PERIOD_ns=20, so `done` goes high after 9 enabled cycles.
1. Reset held 3 cycles with `button_n`=0 → all outputs 0 during reset. `held` rises 7 edges after reset release.
2. `button_n` low for 3 cycles, then high → `held`, `long_clear`, `short_press` and `long_press` stay 0 throughout.
3. `button_n` low for 8 cycles → `held` and a one-cycle `long_clear` at edge 7, `long_enable` high. After release, exactly one `short_press` pulse and no `long_press`.
4. `button_n` low for 40 cycles → one `long_press` pulse ~10 cycles after `held` rises, `long_enable` drops. `long_held`=1 until 7 edges after release, then 0. No `short_press`.
5. `reset` asserted for 2 cycles in TIMING with the button still low → outputs 0 immediately, no event. A fresh `long_clear` 7 edges after reset release, and `long_press` only after a full 9 further enabled cycles.
6. Force the debounced release and `long_done` high in the same TIMING cycle → one `long_press`, no `short_press`, state back in IDLE 2 edges later.
